// File: rtl/hbridge_driver.sv
`default_nettype none
// ============================================================================
// Module   : hbridge_driver
// Purpose  : Dual H-bridge (L298-class) driver. Debounces per-motor direction
//            and enable commands, enforces a de-energised dead time before any
//            new drive, and soft-starts each motor with a PWM duty ramp.
// Revision : 1.0  initial release
// ============================================================================
module hbridge_driver #(
  parameter int PWM_BITS      = 8,
  parameter int DUTY_MAX      = 230,
  parameter int RAMP_STEP     = 8,
  parameter int RAMP_DIV      = 4,
  parameter int DEAD_CYCLES   = 1000,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motorIn,
  input  logic [1:0] motorEn,
  output logic [3:0] hb_in,
  output logic [1:0] hb_en,
  output logic [1:0] busy
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PWM_BITS:0]   DUTY_MAX_W  = DUTY_MAX[PWM_BITS:0];
  localparam logic [PWM_BITS:0]   RAMP_STEP_W = RAMP_STEP[PWM_BITS:0];
  localparam logic [DW-1:0]       DEAD_W      = DEAD_CYCLES[DW-1:0];
  localparam logic [FW-1:0]       FILTER_W    = FILTER_CYCLES[FW-1:0];
  localparam logic [FW-1:0]       FILTER_M1   = FW'(FILTER_CYCLES - 1);
  localparam logic [RW-1:0]       DIV_LAST    = RW'(RAMP_DIV - 1);

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_BRAKE = 2'b11;
  localparam logic [1:0] CMD_FWD   = 2'b10;
  localparam logic [1:0] CMD_REV   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BRAKE = 3'd1,
    S_DEAD  = 3'd2,
    S_RAMP  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;

  // Shared free-running PWM counter; both motors step their duty at its wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign wrap = &pwm_cnt;

  for (genvar m = 0; m < 2; m++) begin : g_motor
    logic [1:0]          cmd;
    logic [1:0]          prev;
    logic [FW-1:0]       fcnt;
    logic                acc;
    logic                acc_dir;
    logic [DW-1:0]       dead_cnt;
    logic                dead_ok;
    logic                energised;
    state_t              state;
    state_t              nstate;
    logic [1:0]          target;
    logic [1:0]          ntarget;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] nduty;
    logic [RW-1:0]       div;
    logic [RW-1:0]       ndiv;
    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS:0]   clamped;
    logic [1:0]          pair;
    logic                en;
    logic                bsy;

    // A disabled motor is simply a coast request
    assign cmd = motorEn[m] ? motorIn[2*m+1:2*m] : CMD_COAST;

    // Stability filter: any change restarts the count, one accept per change
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev <= CMD_COAST;
        fcnt <= '0;
      end else if (cmd != prev) begin
        prev <= cmd;
        fcnt <= FW'(1);
      end else if (fcnt < FILTER_W) begin
        fcnt <= fcnt + 1'b1;
      end
    end

    // Accept fires on the cycle the command completes its stable window
    always_comb begin
      acc = 1'b0;
      if (cmd == prev) acc = (fcnt == FILTER_M1);
      else             acc = (FILTER_CYCLES == 1);
    end

    assign acc_dir   = acc && ((cmd == CMD_FWD) || (cmd == CMD_REV));
    assign energised = en || (pair == CMD_BRAKE);
    assign dead_ok   = (dead_cnt >= DEAD_W);

    // Dead-time counter tracks what the bridge pins actually do
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 dead_cnt <= DEAD_W;
      else if (energised)         dead_cnt <= '0;
      else if (dead_cnt < DEAD_W) dead_cnt <= dead_cnt + 1'b1;
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= S_IDLE;
        target <= CMD_COAST;
        duty   <= '0;
        div    <= '0;
      end else begin
        state  <= nstate;
        target <= ntarget;
        duty   <= nduty;
        div    <= ndiv;
      end
    end

    assign sum     = {1'b0, duty} + RAMP_STEP_W;
    assign clamped = (sum >= DUTY_MAX_W) ? DUTY_MAX_W : sum;

    // Next-state logic; a cold bridge skips the dead wait entirely
    always_comb begin
      nstate  = state;
      ntarget = target;
      nduty   = duty;
      ndiv    = div;
      case (state)
        S_IDLE, S_BRAKE: begin
          if (acc && cmd == CMD_BRAKE) begin
            nstate = S_BRAKE;
          end else if (acc && cmd == CMD_COAST) begin
            nstate = S_IDLE;
          end else if (acc_dir) begin
            ntarget = cmd;
            nstate  = dead_ok ? S_RAMP : S_DEAD;
          end
        end
        S_DEAD: begin
          if (acc && cmd == CMD_COAST)      nstate  = S_IDLE;
          else if (acc && cmd == CMD_BRAKE) nstate  = S_BRAKE;
          else if (acc_dir)                 ntarget = cmd;
          else if (dead_ok)                 nstate  = S_RAMP;
        end
        S_RAMP, S_RUN: begin
          if (acc && cmd == CMD_COAST) begin
            nstate = S_IDLE;
          end else if (acc && cmd == CMD_BRAKE) begin
            nstate = S_BRAKE;
          end else if (acc_dir && cmd != target) begin
            ntarget = cmd;
            nstate  = S_DEAD;
          end else if (state == S_RAMP && wrap) begin
            if (div == DIV_LAST) begin
              ndiv  = '0;
              nduty = clamped[PWM_BITS-1:0];
              if (clamped >= DUTY_MAX_W) nstate = S_RUN;
            end else begin
              ndiv = div + 1'b1;
            end
          end
        end
        default: nstate = S_IDLE;
      endcase
      // Any exit from driving drops the duty so the next ramp starts from zero
      if (nstate != S_RAMP && nstate != S_RUN) begin
        nduty = '0;
        ndiv  = '0;
      end
    end

    // Registered bridge pins derived from the current state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pair <= CMD_COAST;
        en   <= 1'b0;
        bsy  <= 1'b0;
      end else begin
        case (state)
          S_BRAKE:      pair <= CMD_BRAKE;
          S_RAMP, S_RUN: pair <= target;
          default:      pair <= CMD_COAST;
        endcase
        en  <= (state == S_BRAKE) ||
               (((state == S_RAMP) || (state == S_RUN)) && (pwm_cnt < duty));
        bsy <= (state == S_DEAD) || (state == S_RAMP);
      end
    end

    assign hb_in[2*m+1:2*m] = pair;
    assign hb_en[m]         = en;
    assign busy[m]          = bsy;
  end

endmodule
`default_nettype wire
